// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the 16x8 FIFO read side and the UART transmitter,
// plus the serial line and status outputs.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_re,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_re,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO one byte at a time and sends each byte as an
// LSB-first 8N1 UART frame on tx.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shift;
  logic                tx_q;
  logic                bit_end;

  assign bit_end        = (cnt == CNT_LAST);
  assign bus.tx         = tx_q;
  assign bus.fifo_re    = (state == POP);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          cnt  <= '0;
          if (!bus.fifo_empty) state <= POP;
        end
        POP: begin
          cnt   <= '0;
          state <= LOAD;
        end
        // Registered FIFO read: data_out is valid now, one cycle after re.
        LOAD: begin
          shift   <= bus.fifo_data;
          bit_idx <= '0;
          cnt     <= '0;
          tx_q    <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              tx_q <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            cnt   <= '0;
            state <= bus.fifo_empty ? IDLE : POP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
